fibonacci_circuit: RTL and testbench



---
 rtl/fibonacci_circuit.sv | 35 +++
 tb/tb_fibonacci_circuit.sv | 112 +++++++++++
 2 files changed

// File: rtl/fibonacci_circuit.sv
// Free-running 32-bit Fibonacci generator: one term per clock on num, restarting
// at 0 after F47 so the output never shows a wrapped sum.
module fibonacci_circuit (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] num
);

  localparam logic [31:0] F_LAST = 32'd2971215073;

  logic [31:0] r_num;
  logic [31:0] r_nxt;
  logic [31:0] w_sum;
  logic        w_restart;

  assign w_sum     = r_num + r_nxt;
  assign w_restart = (r_num == F_LAST);

  // At (F46, F47) the sum wraps; the restart on the following edge hides it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num <= 32'd0;
      r_nxt <= 32'd1;
    end else if (w_restart) begin
      r_num <= 32'd0;
      r_nxt <= 32'd1;
    end else begin
      r_num <= r_nxt;
      r_nxt <= w_sum;
    end
  end

  assign num = r_num;

endmodule

// File: tb/tb_fibonacci_circuit.sv
// Directed bench for fibonacci_circuit: reset, startup terms, deep terms,
// restart after F47, a 500-cycle model sweep and an asynchronous mid-run reset.
module tb_fibonacci_circuit;

  logic        clk;
  logic        reset_n;
  logic [31:0] num;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  longint fib_tab [0:47];

  fibonacci_circuit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .num     (num)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] expv);
    checks++;
    assert (num === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, num, expv);
    end
  endtask

  function automatic logic is_fib(input logic [31:0] v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 48; i++)
      if (fib_tab[i] == longint'(v)) hit = 1'b1;
    return hit;
  endfunction

  // Advance one rising edge, sample mid-cycle, compare against the model table.
  task automatic step();
    logic legal;
    @(posedge clk);
    #5;
    k++;
    check("model", fib_tab[k % 48][31:0]);
    legal = is_fib(num);
    checks++;
    assert (legal === 1'b1 && num !== 32'd512559680) else begin
      errors++;
      $error("FAIL legal observed=%0d expected=fibonacci_value", num);
    end
  endtask

  initial begin
    fib_tab[0] = 0;
    fib_tab[1] = 1;
    for (int i = 2; i < 48; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];

    reset_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("reset_hold", 32'd0);
    end
    reset_n = 1'b1;

    step(); check("edge1", 32'd1);
    step(); check("edge2", 32'd1);
    step(); check("edge3", 32'd2);
    step(); check("edge4", 32'd3);
    step(); check("edge5", 32'd5);
    step(); check("edge6", 32'd8);
    step(); check("edge7", 32'd13);
    step(); check("edge8", 32'd21);

    while (k < 30) step();
    check("edge30", 32'd832040);
    while (k < 40) step();
    check("edge40", 32'd102334155);
    while (k < 46) step();
    check("edge46", 32'd1836311903);
    step(); check("edge47", 32'd2971215073);
    step(); check("edge48_restart", 32'd0);
    step(); check("edge49", 32'd1);
    step(); check("edge50", 32'd1);
    while (k < 96) step();
    check("edge96_restart", 32'd0);

    while (k < 500) step();

    // Stop on a term of 55 (F10), then pull reset between edges.
    while ((k % 48) != 10) step();
    check("pre_reset_55", 32'd55);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_immediate", 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("async_reset_hold", 32'd0);
    end
    reset_n = 1'b1;
    k = 0;
    step(); check("post_reset_edge1", 32'd1);
    step(); check("post_reset_edge2", 32'd1);
    step(); check("post_reset_edge3", 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
